// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, oversampling edge count,
// data deserialisation, parity/stop checking and result reporting.
module uart_rx_ctrl #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      sampled_bit,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic                      dat_samp_en,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;
    logic                      par_fail_q, par_fail_d;
    logic                      bit_end;

    assign bit_end = (edge_cnt_q == Prescale - PRESCALE_WIDTH'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            par_fail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            par_fail_q   <= par_fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = '0;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        par_fail_d   = par_fail_q;

        if (state_q != S_IDLE) begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                par_fail_d = 1'b0;
                // The detect cycle itself is edge 0 of the start bit.
                if (!RX_IN) begin
                    state_d    = S_START;
                    edge_cnt_d = PRESCALE_WIDTH'(1);
                end
            end
            S_START: begin
                if (bit_end) begin
                    if (sampled_bit) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = DATA_WIDTH'({sampled_bit, shift_q} >> 1);
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    if (sampled_bit != ((^shift_q) ^ PAR_TYP)) begin
                        par_fail_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d   = S_IDLE;
                    stp_err_d = ~sampled_bit;
                    par_err_d = par_fail_q;
                    if (sampled_bit && !par_fail_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign edge_cnt    = edge_cnt_q;
    assign dat_samp_en = (state_q != S_IDLE);
    assign P_DATA      = p_data_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised scoreboard bench for uart_rx_ctrl with a frame-level
// reference model of edge counting and result pulses.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic [5:0] edge_cnt;
    logic       dat_samp_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_ctrl #(.PRESCALE_WIDTH(6), .DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
        .edge_cnt(edge_cnt), .dat_samp_en(dat_samp_en), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int       cyc;
        bit       dv;
        bit       pe;
        bit       se;
        bit [7:0] data;
    } exp_t;

    typedef struct {
        int det;
        int len;
        int p;
    } win_t;

    exp_t     exp_q[$];
    win_t     cur_w;
    int       cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;
    bit [7:0] last_data = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle edge/enable model plus pulse scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        bit   en;
        int   ee;
        en = (cur_w.len > 0) && (cyc > cur_w.det)
             && (cyc < cur_w.det + cur_w.len);
        ee = en ? (cyc - cur_w.det) % cur_w.p : 0;
        chk("dat_samp_en", int'(dat_samp_en), int'(en));
        chk("edge_cnt", int'(edge_cnt), ee);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("missing_pulse", 0, e.cyc);
        end
        if (data_valid || par_err || stp_err) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data_valid", int'(data_valid), int'(e.dv));
                chk("par_err", int'(par_err), int'(e.pe));
                chk("stp_err", int'(stp_err), int'(e.se));
                chk("P_DATA", int'(P_DATA), int'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            RX_IN       = 1'b1;
            sampled_bit = 1'($urandom);
            tick();
        end
    endtask

    task automatic set_cfg(input int p, input bit pe, input bit pt);
        Prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
    endtask

    task automatic send_frame(input bit [7:0] d, input bit bad_par,
                              input bit bad_stp, input int abort);
        bit   bits[$];
        exp_t e;
        int   p;
        int   n;
        p = int'(Prescale);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR_EN) bits.push_back((^d) ^ PAR_TYP ^ bad_par);
        bits.push_back(~bad_stp);
        cur_w = '{det: cyc, len: bits.size() * p, p: p};
        e.cyc = cyc + bits.size() * p;
        e.se  = bad_stp;
        e.pe  = PAR_EN && bad_par;
        e.dv  = !(e.se || e.pe);
        if (e.dv) last_data = d;
        e.data = last_data;
        exp_q.push_back(e);
        n = 0;
        foreach (bits[k]) begin
            for (int j = 0; j < p; j++) begin
                if (abort > 0 && n == abort) begin
                    RST = 1'b0;
                    void'(exp_q.pop_back());
                    cur_w.len = 0;
                    last_data = 8'h00;
                    #1;
                    chk("abort_edge_cnt", int'(edge_cnt), 0);
                    chk("abort_samp_en", int'(dat_samp_en), 0);
                    chk("abort_P_DATA", int'(P_DATA), 0);
                    chk("abort_pulses",
                        int'({data_valid, par_err, stp_err}), 0);
                    RX_IN = 1'b1;
                    repeat (3) @(posedge CLK);
                    #1;
                    RST = 1'b1;
                    return;
                end
                RX_IN       = bits[k];
                sampled_bit = (j == p - 1) ? bits[k] : 1'($urandom);
                n++;
                tick();
            end
        end
    endtask

    task automatic glitch(input int low);
        int p;
        p = int'(Prescale);
        cur_w = '{det: cyc, len: p, p: p};
        for (int j = 0; j < p; j++) begin
            RX_IN       = (j < low) ? 1'b0 : 1'b1;
            sampled_bit = (j == p - 1) ? 1'b1 : 1'($urandom);
            tick();
        end
    endtask

    initial begin
        int psel[3];
        psel = '{8, 16, 32};
        cur_w = '{det: 0, len: 0, p: 8};
        RST = 1'b0;
        RX_IN = 1'b1;
        sampled_bit = 1'b0;
        set_cfg(8, 1'b0, 1'b0);
        #3;
        chk("rst_edge_cnt", int'(edge_cnt), 0);
        chk("rst_samp_en", int'(dat_samp_en), 0);
        chk("rst_P_DATA", int'(P_DATA), 0);
        chk("rst_pulses", int'({data_valid, par_err, stp_err}), 0);
        tick();
        tick();
        RST = 1'b1;
        idle(3);

        set_cfg(8, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        idle(3);
        set_cfg(16, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        idle(2);
        set_cfg(8, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 0);
        idle(2);
        glitch(2);
        chk("glitch_edge_cnt", int'(edge_cnt), 0);
        chk("glitch_samp_en", int'(dat_samp_en), 0);
        idle(2);
        set_cfg(32, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 0);
        send_frame(8'h00, 1'b0, 1'b0, 0);
        idle(2);
        set_cfg(8, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 20);
        idle(2);
        send_frame(8'h81, 1'b0, 1'b0, 0);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            int r;
            if ($urandom_range(0, 3) == 0) begin
                set_cfg(psel[$urandom_range(0, 2)], 1'($urandom),
                        1'($urandom));
            end
            r = $urandom_range(0, 19);
            if (r == 0) begin
                glitch($urandom_range(1, 3));
            end else if (r == 1) begin
                send_frame(8'($urandom), 1'b0, 1'b0,
                           $urandom_range(1, 9 * int'(Prescale)));
            end else begin
                send_frame(8'($urandom), ($urandom_range(0, 5) == 0),
                           ($urandom_range(0, 6) == 0), 0);
            end
            idle($urandom_range(0, 3));
        end

        idle(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
